// File: rtl/xillybus_pipe_pkg.sv
// Shared types and sizing helpers for the Xillybus read-pipe FIFO.
// The EOF state encoding is visible to checkers and benches through this package.
package xillybus_pipe_pkg;

  localparam int PIPE_W = 32;

  typedef enum logic [1:0] {
    STREAM   = 2'd0,
    EOF_PEND = 2'd1,
    EOF      = 2'd2,
    FLUSH    = 2'd3
  } eof_state_t;

  // Level counter needs one extra bit so that a completely full FIFO is representable.
  function automatic int level_width(input int depth_log2);
    return depth_log2 + 1;
  endfunction

endpackage

// File: rtl/xillybus_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output, single clock.
// The read register resets to zero and holds its value when no read is issued.
module xillybus_sdp_ram #(
  parameter int AW = 9,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [0:(2**AW)-1];

  // Storage array write port; left without reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port; the previous word stays visible until the next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= {DW{1'b0}};
    end else if (re) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/xillybus_rd32_fifo.sv
// Producer-to-core FIFO for the 32-bit Xillybus read pipe: standard (non-FWFT) read side,
// end-of-file signalled once the stream drains, and a one-cycle flush whenever the host closes the file.
module xillybus_rd32_fifo
  import xillybus_pipe_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9,
  parameter int AFULL_GAP  = 4
) (
  input  logic              bus_clk_w,
  input  logic              bus_rst_w,
  input  logic [PIPE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_eof,
  output logic              in_afull,
  input  logic              user_r_read_32_open_w,
  input  logic              user_r_read_32_rden_w,
  output logic [PIPE_W-1:0] user_r_read_32_data_w,
  output logic              user_r_read_32_empty_w,
  output logic              user_r_read_32_eof_w,
  output logic [DEPTH_LOG2:0] level,
  output logic              overflow
);

  localparam int LW = level_width(DEPTH_LOG2);
  localparam logic [LW-1:0] LVL_ONE = {{(LW-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0] DEPTH_L = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [LW-1:0] GAP_L   = AFULL_GAP[LW-1:0];

  eof_state_t    state_r;
  eof_state_t    state_next_s;
  logic [LW-1:0] wptr_r;
  logic [LW-1:0] rptr_r;
  logic [LW-1:0] level_r;
  logic [LW-1:0] level_next_s;
  logic          empty_r;
  logic          afull_r;
  logic          ovf_r;
  logic          eof_r;
  logic          open_d_r;
  logic          full_s;
  logic          close_s;
  logic          accepting_s;
  logic          in_ready_s;
  logic          wr_en_s;
  logic          rd_en_s;

  // EOF state register.
  always_ff @(posedge bus_clk_w) begin
    if (bus_rst_w) begin
      state_r <= STREAM;
    end else begin
      state_r <= state_next_s;
    end
  end

  // EOF next state; a close overrides everything so every open starts from a clean pipe.
  always_comb begin
    state_next_s = state_r;
    if (close_s) begin
      state_next_s = FLUSH;
    end else begin
      case (state_r)
        STREAM: begin
          if (in_eof && user_r_read_32_open_w) begin
            state_next_s = EOF_PEND;
          end else begin
            state_next_s = STREAM;
          end
        end
        EOF_PEND: begin
          // Look at the post-edge level so eof rises together with empty.
          if ((level_next_s == {LW{1'b0}}) && !wr_en_s) begin
            state_next_s = EOF;
          end else begin
            state_next_s = EOF_PEND;
          end
        end
        EOF:     state_next_s = EOF;
        FLUSH:   state_next_s = STREAM;
        default: state_next_s = STREAM;
      endcase
    end
  end

  // Handshake decode and next level, all derived from registered pointers and state.
  always_comb begin
    full_s      = (wptr_r[LW-1] != rptr_r[LW-1]) && (wptr_r[LW-2:0] == rptr_r[LW-2:0]);
    close_s     = open_d_r && !user_r_read_32_open_w;
    accepting_s = (state_r == STREAM) || (state_r == EOF_PEND);
    in_ready_s  = user_r_read_32_open_w && !full_s && !bus_rst_w && accepting_s;
    wr_en_s     = in_valid && in_ready_s;
    rd_en_s     = user_r_read_32_rden_w && !empty_r && !bus_rst_w && accepting_s;
    case ({wr_en_s, rd_en_s})
      2'b10:   level_next_s = level_r + LVL_ONE;
      2'b01:   level_next_s = level_r - LVL_ONE;
      default: level_next_s = level_r;
    endcase
  end

  // Pointers, level and flags; the FLUSH cycle discards content by snapping rptr to wptr.
  always_ff @(posedge bus_clk_w) begin
    if (bus_rst_w) begin
      wptr_r   <= {LW{1'b0}};
      rptr_r   <= {LW{1'b0}};
      level_r  <= {LW{1'b0}};
      empty_r  <= 1'b1;
      afull_r  <= 1'b0;
      ovf_r    <= 1'b0;
      eof_r    <= 1'b0;
      open_d_r <= 1'b0;
    end else begin
      open_d_r <= user_r_read_32_open_w;
      eof_r    <= (state_next_s == EOF);
      if (state_r == FLUSH) begin
        rptr_r  <= wptr_r;
        level_r <= {LW{1'b0}};
        empty_r <= 1'b1;
        afull_r <= 1'b0;
        ovf_r   <= 1'b0;
      end else begin
        if (wr_en_s) begin
          wptr_r <= wptr_r + LVL_ONE;
        end
        if (rd_en_s) begin
          rptr_r <= rptr_r + LVL_ONE;
        end
        level_r <= level_next_s;
        empty_r <= (level_next_s == {LW{1'b0}});
        afull_r <= ((DEPTH_L - level_next_s) <= GAP_L);
        if (in_valid && !in_ready_s && user_r_read_32_open_w) begin
          ovf_r <= 1'b1;
        end
      end
    end
  end

  xillybus_sdp_ram #(
    .AW (DEPTH_LOG2),
    .DW (PIPE_W)
  ) u_ram (
    .clk   (bus_clk_w),
    .rst   (bus_rst_w),
    .we    (wr_en_s),
    .waddr (wptr_r[LW-2:0]),
    .wdata (in_data),
    .re    (rd_en_s),
    .raddr (rptr_r[LW-2:0]),
    .rdata (user_r_read_32_data_w)
  );

  assign in_ready               = in_ready_s;
  assign in_afull               = afull_r;
  assign user_r_read_32_empty_w = empty_r;
  assign user_r_read_32_eof_w   = eof_r;
  assign level                  = level_r;
  assign overflow               = ovf_r;

endmodule
